// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants for the core front end.
package core_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0]   RESET_PC_DEFAULT = 32'h0000_0000;
  // Word the instruction BRAM presents on its output while held in reset.
  localparam logic [INST_W-1:0] INVALID_INST     = 32'hFFFF_FFFF;

  // One fetched instruction together with the byte address it came from.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // The BRAM indexes by word, so the low two address bits are always cleared.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage signal bundle: BRAM read port, redirect input, and decode handoff.
interface fetch_if;
  import core_pkg::*;

  logic              imem_en;
  logic [XLEN-1:0]   imem_addr;
  logic [INST_W-1:0] imem_dout;
  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [XLEN-1:0]   out_pc;

  // Fetch unit side.
  modport master (
    output imem_en, imem_addr, out_valid, out_inst, out_pc,
    input  imem_dout, redirect, redirect_pc, out_ready
  );

  // BRAM, branch unit and decode side.
  modport slave (
    input  imem_en, imem_addr, out_valid, out_inst, out_pc,
    output imem_dout, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit_skid_buf.sv
// Two-entry {pc,inst} skid FIFO between the BRAM response and decode.
// The head entry lives in its own register so decode sees registered outputs.
module fetch_skid_buf
  import core_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [1:0]   count
);

  fetch_entry_t head_q;
  fetch_entry_t tail_q;
  logic [1:0]   count_q;

  // Occupancy and shift storage; flush wins over push, and a pop shifts tail into head.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      // NOTE: the storage is cleared as well, so the head reads all-zero after reset, not stale data.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= din;
          else                 tail_q <= din;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Pop on an empty FIFO cannot happen, so only one or two entries occur here.
          if (count_q == 2'd1) begin
            head_q <= din;
          end else begin
            head_q <= tail_q;
            tail_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = head_q;
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one BRAM read per cycle while credit allows,
// and flushes all stale fetches on a branch/jump redirect.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            req_q;
  logic [1:0]      count;
  logic            push;
  logic            pop;
  logic            issue;
  logic [2:0]      occupancy;
  logic [XLEN-1:0] fetch_addr;
  fetch_entry_t    resp;
  fetch_entry_t    head;

  // A redirect hides the head and blocks the pop in the same cycle it flushes.
  assign bus.out_valid = (count != 2'd0) & ~bus.redirect;
  assign pop           = bus.out_valid & bus.out_ready;

  // The BRAM word belongs to whatever was issued last cycle, unless a redirect makes it stale.
  assign push = req_q & ~bus.redirect;
  assign resp = '{pc: req_pc_q, inst: bus.imem_dout};

  // Credit check and fetch address: issue only if the word can land in the FIFO after this cycle's pop.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    occupancy  = 3'({1'b0, count}) + 3'({2'b00, req_q}) - 3'({2'b00, pop});
    fetch_addr = pc_q;
    issue      = 1'b0;
    if (bus.redirect) fetch_addr = word_align(bus.redirect_pc);
    if (!rst) issue = bus.redirect | (occupancy <= 3'(DEPTH - 1));
  end

  assign bus.imem_en   = issue;
  assign bus.imem_addr = fetch_addr;

  // PC and outstanding-request tracking; the address arithmetic wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      req_pc_q <= '0;
    end else if (issue) begin
      pc_q     <= fetch_addr + XLEN'(4);
      req_q    <= 1'b1;
      req_pc_q <= fetch_addr;
    end else begin
      req_q    <= 1'b0;
    end
  end

  fetch_skid_buf u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .din   (resp),
    .dout  (head),
    .count (count)
  );

  assign bus.out_inst = head.inst;
  assign bus.out_pc   = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: BRAM model (word i = A000_0000+i), an expected-stream
// scoreboard compared on every decode handshake, and directed timing checks.
module tb_fetch_unit;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst;

  fetch_if f ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (f)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   pops  = 0;

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    logic [31:0] idx;
    idx = addr >> 2;
    return 32'hA000_0000 + idx;
  endfunction

  // BRAM model: 1-cycle latency, holds dout when not enabled, all-ones while in reset.
  always @(posedge clk) begin
    if (rst)            f.imem_dout <= 32'hFFFF_FFFF;
    else if (f.imem_en) f.imem_dout <= word_at(f.imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // The program-order stream decode must see after a restart at 'start'.
  task automatic expect_stream(input logic [31:0] start);
    logic [31:0] a;
    a = start & ~32'h3;
    sb.delete();
    for (int i = 0; i < 128; i++) begin
      sb.push_back('{pc: a, inst: word_at(a)});
      a = a + 32'd4;
    end
  endtask

  // Every accepted instruction must be the next one in the expected stream.
  always @(negedge clk) begin
    if (!rst && f.out_valid && f.out_ready) begin
      pops++;
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pop_pc", f.out_pc, e.pc);
        check("pop_inst", f.out_inst, e.inst);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    f.redirect    = 1'b0;
    f.redirect_pc = 32'h0;
    f.out_ready   = 1'b1;
    expect_stream(32'h0);

    // Reset: no BRAM reads while rst is high.
    cyc(); #1;
    check("rst_imem_en", 32'(f.imem_en), 32'd0);
    cyc();

    // Test 1: release at T0, valid from T2, one per cycle.
    rst = 1'b0; #1;
    check("t0_valid", 32'(f.out_valid), 32'd0);
    check("t0_en", 32'(f.imem_en), 32'd1);
    check("t0_addr", f.imem_addr, 32'h0);
    cyc(); #1;
    check("t1_valid", 32'(f.out_valid), 32'd0);
    cyc(); #1;
    check("t2_inst", f.out_inst, 32'hA000_0000);
    for (int i = 0; i < 4; i++) begin
      check("stream_valid", 32'(f.out_valid), 32'd1);
      check("stream_pc", f.out_pc, 32'(4 * i));
      cyc(); #1;
    end

    // Test 2: head is pc 0x10; stall 6 cycles.
    check("stall_head_pc", f.out_pc, 32'h10);
    f.out_ready = 1'b0;
    for (int s = 0; s < 6; s++) begin
      #1;
      check("stall_valid", 32'(f.out_valid), 32'd1);
      check("stall_pc", f.out_pc, 32'h10);
      check("stall_inst", f.out_inst, 32'hA000_0004);
      if (s >= 2) check("stall_en", 32'(f.imem_en), 32'd0);
      cyc();
    end
    f.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("release_pc", f.out_pc, 32'h10 + 32'(4 * k));
      cyc();
    end

    // Test 3: FIFO full while stalled, then redirect to 0x100.
    f.out_ready = 1'b0;
    repeat (3) cyc();
    f.redirect    = 1'b1;
    f.redirect_pc = 32'h100;
    expect_stream(32'h100);
    #1;
    check("rd3_valid_t", 32'(f.out_valid), 32'd0);
    check("rd3_en_t", 32'(f.imem_en), 32'd1);
    check("rd3_addr_t", f.imem_addr, 32'h100);
    cyc();
    f.redirect  = 1'b0;
    f.out_ready = 1'b1;
    #1;
    check("rd3_valid_t1", 32'(f.out_valid), 32'd0);
    cyc(); #1;
    check("rd3_valid_t2", 32'(f.out_valid), 32'd1);
    check("rd3_pc_t2", f.out_pc, 32'h100);
    check("rd3_inst_t2", f.out_inst, 32'hA000_0040);
    repeat (4) cyc();

    // Test 4: redirect to 0x103 while streaming with ready=1.
    check("rd4_pre_valid", 32'(f.out_valid), 32'd1);
    f.redirect    = 1'b1;
    f.redirect_pc = 32'h103;
    expect_stream(32'h100);
    #1;
    check("rd4_valid_t", 32'(f.out_valid), 32'd0);
    check("rd4_addr_t", f.imem_addr, 32'h100);
    cyc();
    f.redirect = 1'b0;
    #1;
    check("rd4_valid_t1", 32'(f.out_valid), 32'd0);
    cyc(); #1;
    check("rd4_pc_t2", f.out_pc, 32'h100);
    check("rd4_inst_t2", f.out_inst, 32'hA000_0040);
    repeat (3) cyc();

    // Test 5: one-cycle reset mid-stream.
    rst = 1'b1;
    expect_stream(32'h0);
    #1;
    check("rst5_en", 32'(f.imem_en), 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    check("rst5_valid_r1", 32'(f.out_valid), 32'd0);
    check("rst5_pc_r1", f.out_pc, 32'h0);
    check("rst5_inst_r1", f.out_inst, 32'h0);
    cyc(); #1;
    check("rst5_valid_r2", 32'(f.out_valid), 32'd0);
    cyc(); #1;
    check("rst5_valid_r3", 32'(f.out_valid), 32'd1);
    check("rst5_pc_r3", f.out_pc, 32'h0);
    check("rst5_inst_r3", f.out_inst, 32'hA000_0000);
    repeat (2) cyc();

    // Test 6: PC wrap at the top of the address space.
    f.redirect    = 1'b1;
    f.redirect_pc = 32'hFFFF_FFFC;
    expect_stream(32'hFFFF_FFFC);
    cyc();
    f.redirect = 1'b0;
    cyc(); #1;
    check("wrap_pc0", f.out_pc, 32'hFFFF_FFFC);
    check("wrap_inst0", f.out_inst, 32'hDFFF_FFFF);
    cyc(); #1;
    check("wrap_pc1", f.out_pc, 32'h0);
    cyc(); #1;
    check("wrap_pc2", f.out_pc, 32'h4);
    repeat (3) cyc();

    check("pops_seen", 32'(pops > 15), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
